// File: rtl/stride_prefetch_gen.sv
// Stride-training prefetch generator: learns a constant demand-access stride and,
// once confident, pushes a burst of predicted addresses into the prefetch queue.
module stride_prefetch_gen #(
  parameter int ADDR_BITS      = 32,
  parameter int PREFETCH_DEPTH = 4,
  parameter int CONF_THRESH    = 2
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 accessEn,
  input  logic [ADDR_BITS-1:0] accessAddr,
  input  logic                 flush,
  input  logic                 qFull,
  output logic                 pushEn,
  output logic [ADDR_BITS-1:0] inVector,
  output logic [ADDR_BITS-1:0] curStride,
  output logic                 confident
);

  localparam int CONF_W = $clog2(CONF_THRESH + 1);
  localparam int CNT_W  = $clog2(PREFETCH_DEPTH + 1);
  localparam logic [CONF_W-1:0] CONF_MAX = CONF_W'(CONF_THRESH);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(PREFETCH_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRAIN = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] last_q, last_d;
  logic [ADDR_BITS-1:0] stride_q, stride_d;
  logic [CONF_W-1:0]    conf_q, conf_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] next_q, next_d;
  logic [ADDR_BITS-1:0] delta;
  logic [CONF_W-1:0]    conf_inc;

  assign pushEn    = (state_q == ISSUE) && !qFull;
  assign inVector  = next_q;
  assign curStride = stride_q;
  assign confident = (conf_q == CONF_MAX);

  assign delta    = accessAddr - last_q;
  assign conf_inc = (conf_q == CONF_MAX) ? conf_q : conf_q + CONF_W'(1);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    stride_d = stride_q;
    conf_d   = conf_q;
    cnt_d    = cnt_q;
    next_d   = next_q;
    if (flush) begin
      state_d  = IDLE;
      last_d   = '0;
      stride_d = '0;
      conf_d   = '0;
      cnt_d    = '0;
      next_d   = '0;
    end else if (state_q == IDLE) begin
      if (accessEn) begin
        last_d  = accessAddr;
        conf_d  = '0;
        state_d = TRAIN;
      end
    end else begin
      // Burst advance first; a nonzero-delta access below overrides it.
      if (state_q == ISSUE && pushEn) begin
        next_d = next_q + stride_q;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = TRAIN;
      end
      if (accessEn && delta != '0) begin
        last_d = accessAddr;
        if (delta != stride_q) begin
          stride_d = delta;
          conf_d   = '0;
          cnt_d    = '0;
          next_d   = next_q;
          state_d  = TRAIN;
        end else begin
          conf_d = conf_inc;
          if (conf_inc == CONF_MAX) begin
            next_d  = accessAddr + stride_q;
            cnt_d   = CNT_FULL;
            state_d = ISSUE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      last_q   <= '0;
      stride_q <= '0;
      conf_q   <= '0;
      cnt_q    <= '0;
      next_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      stride_q <= stride_d;
      conf_q   <= conf_d;
      cnt_q    <= cnt_d;
      next_q   <= next_d;
    end
  end

endmodule

// File: doc/stride_prefetch_gen.md
# stride_prefetch_gen

Stride-training prefetch generator that sits directly upstream of the prefetch address queue (the `doubleQueue` shift-register stage). It observes the demand access stream and learns a constant address stride with a saturating confidence counter. Once the stride is confirmed, it emits a burst of predicted addresses into the queue through the queue's `pushEn`/`inVector` inputs. A `qFull` back-pressure input holds the burst while the queue cannot accept data.

## Interface
- `ADDR_BITS`, 32, width of demand and prefetch addresses (matches queue `DATA_BITS`).
- `PREFETCH_DEPTH`, 4, addresses emitted per trigger; legal range ≥1.
- `CONF_THRESH`, 2, number of consecutive matching strides required to trigger; legal range ≥1.

- `clk`  in  1  single clock, rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `accessEn`  in  1  demand access observed this cycle.
- `accessAddr`  in  ADDR_BITS  demand access address.
- `flush`  in  1  synchronous clear of all training and burst state.
- `qFull`  in  1  downstream queue cannot accept a push this cycle.
- `pushEn`  out  1  push strobe to the queue.
- `inVector`  out  ADDR_BITS  prefetch address presented with `pushEn`.
- `curStride`  out  ADDR_BITS  current trained stride (two's complement).
- `confident`  out  1  high when the confidence counter equals `CONF_THRESH`.

## Operation
- **State registers:**
  - `state` ∈ {IDLE, TRAIN, ISSUE}
  - `lastAddr`
  - `stride`
  - `conf`: width clog2(CONF_THRESH+1); saturates at CONF_THRESH.
  - `issueCnt`: width clog2(PREFETCH_DEPTH+1).
  - `nextPf`
- **Address arithmetic:** all addition and subtraction is modulo 2^ADDR_BITS. `delta = accessAddr - lastAddr`. Negative strides are supported by wrap-around.
- **IDLE + accessEn:** `lastAddr <= accessAddr`, `conf <= 0`, go to TRAIN.
- **TRAIN or ISSUE + accessEn, `delta == 0`:** all training and burst state is unchanged.
- **TRAIN or ISSUE + accessEn, `delta != 0`:** `lastAddr <= accessAddr`, then exactly one of the following applies.
  - **Mismatch (`delta != stride`):** `stride <= delta`, `conf <= 0`.
    - If in ISSUE, abort the burst: `issueCnt <= 0`, go to TRAIN.
  - **Match (`delta == stride`):** `conf <= min(conf+1, CONF_THRESH)`.
    - If the new `conf == CONF_THRESH`, trigger: `nextPf <= accessAddr + stride`, `issueCnt <= PREFETCH_DEPTH`, go to ISSUE.
    - A trigger during ISSUE restarts the burst with a full count.
- **ISSUE, no retrigger or abort this cycle:**
  - If `pushEn` is high: `nextPf <= nextPf + stride`, `issueCnt <= issueCnt - 1`.
  - If `issueCnt` was 1, go to TRAIN.
- **Outputs:**
  - `pushEn = (state == ISSUE) && !qFull` (combinational).
  - `inVector = nextPf`.
  - `curStride = stride`.
  - `confident = (conf == CONF_THRESH)`.
- **flush:** takes priority over `accessEn`. Next state is IDLE; `conf`, `stride` and `issueCnt` clear to 0; `lastAddr` and `nextPf` clear to 0. A push in the flush cycle is still allowed if `pushEn` is high.
- **Queue overwrite:** the queue overwrites its last block when full. This block therefore never pushes while `qFull` is high; addresses are held, not dropped.

## Timing
- **Reset (resetN low, asynchronous):**
  - `state` = IDLE, all registers 0.
  - `pushEn` = 0, `inVector` = 0, `curStride` = 0, `confident` = 0.
- **Trigger latency:** the triggering access is sampled at edge N. `pushEn` is high in cycle N+1 with `inVector = accessAddr + stride`, provided `qFull` is low.
- **Burst throughput:** one address per cycle while `qFull` is low. A full burst of PREFETCH_DEPTH pushes takes PREFETCH_DEPTH unstalled cycles, after which `pushEn` drops.
- **qFull high in ISSUE:** `pushEn` is 0; `nextPf` and `issueCnt` hold. Deassertion resumes the burst the same cycle.
- **Simultaneous push and accessEn:** the push in that cycle uses the pre-edge `nextPf`. The training update then takes effect at the edge and overrides the burst increment (abort, retrigger, or no change for zero delta).
- **Reset mid-burst:** the burst is immediately terminated and `pushEn` goes to 0 asynchronously.
- **Confidence saturation:** further matches keep `conf` at CONF_THRESH, and each such match retriggers the burst.

## Test plan
- **Basic trigger:** reset, then accesses 0x100, 0x140, 0x180, 0x1C0 on consecutive cycles, `qFull` = 0 → `curStride` = 0x40; `confident` rises after 0x1C0; `pushEn` high for 4 cycles with `inVector` 0x200, 0x240, 0x280, 0x2C0; then state is TRAIN.
- **Back-pressure:** same trigger with `qFull` = 1 for 3 cycles starting with the second push → the sequence stalls at 0x240 with no duplicate or skipped values; 4 pushes total.
- **Negative stride and wrap:** accesses 0x00000010, 0x00000000, 0xFFFFFFF0, 0xFFFFFFE0 → `curStride` = 0xFFFFFFF0; pushes 0xFFFFFFD0, 0xFFFFFFC0, 0xFFFFFFB0, 0xFFFFFFA0.
- **Abort and retrain:** mid-burst access with mismatching delta 0x80 → `pushEn` low the next cycle, `conf` = 0, `curStride` = 0x80.
  - A repeated access to the same address mid-burst → the burst continues unchanged.
- **Retrigger mid-burst:** matching access 0x200 during the burst → after the current push, the sequence restarts at 0x240 with a full count of 4.
- **Flush and reset:**
  - `flush` with `accessEn` in the same cycle → IDLE, `confident` = 0, `pushEn` = 0 next cycle; the access is ignored.
  - `resetN` pulsed low mid-burst → all outputs 0 immediately.
